// File: rtl/mdu_hilo_pkg.sv
// mdu_hilo_pkg: shared CPU definitions for the multiply/divide unit.
//   WORD_W     - architectural word width
//   mdu_op_e   - MULT/MULTU/DIV/DIVU encodings as presented on the op port
//   mdu_state_e- sequencer states
package mdu_hilo_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_SIGN = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_divstep.sv
// mdu_divstep: one combinational restoring-divide step.
//   rem_i     - partial remainder (always < divisor_i on entry)
//   divisor_i - divisor magnitude
//   bit_i     - next dividend bit, MSB first
//   rem_o     - next partial remainder
//   q_o       - quotient bit produced by this step
module mdu_divstep #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;

  assign shifted = {rem_i, bit_i};
  // When the subtraction succeeds the true difference is below the divisor,
  // so the low WIDTH bits hold it exactly.
  assign trial   = shifted[WIDTH-1:0] - divisor_i;
  assign q_o     = (shifted >= {1'b0, divisor_i});
  assign rem_o   = q_o ? trial : shifted[WIDTH-1:0];

endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit with architectural HI/LO.
//   clk, reset (sync, active low)
//   start/op/rs_data/rt_data - launch MULT/MULTU/DIV/DIVU (accepted in IDLE)
//   mthi/mtlo                - write rs_data to HI/LO (IDLE only)
//   flush                    - abort an in-flight operation
//   busy/done                - operation in flight / one-cycle completion
//   hi/lo                    - HI/LO registers
// Build option: define MDU_FAST_MULT_EN for a single-cycle multiply path.
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e         state_q, state_d;
  mdu_op_e            op_q, op_d;
  logic               sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic               op_signed, op_is_div, is_div_q;
  logic [WIDTH-1:0]   abs_rs, abs_rt;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   div_rem;
  logic               div_qbit;
  logic [WIDTH-1:0]   quo, rem;
  logic [2*WIDTH-1:0] prod_fix;
`ifdef MDU_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
`endif

  assign op_signed = (op == MDU_MULT) || (op == MDU_DIV);
  assign op_is_div = (op == MDU_DIV) || (op == MDU_DIVU);
  assign is_div_q  = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
  assign abs_rs    = (op_signed && rs_data[WIDTH-1]) ? ('0 - rs_data) : rs_data;
  assign abs_rt    = (op_signed && rt_data[WIDTH-1]) ? ('0 - rt_data) : rt_data;

`ifdef MDU_FAST_MULT_EN
  assign fast_prod = {{WIDTH{1'b0}}, abs_rs} * {{WIDTH{1'b0}}, abs_rt};
`endif

  // acc_q holds {upper, lower}. Multiply: upper accumulates, lower holds the
  // multiplier shifting out LSB first. Divide: upper is the remainder, lower
  // holds the dividend shifting out MSB first while quotient bits shift in.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + ({1'b0, mcand_q} & {(WIDTH+1){acc_q[0]}});
  assign quo      = acc_q[WIDTH-1:0];
  assign rem      = acc_q[2*WIDTH-1:WIDTH];
  assign prod_fix = (sa_q ^ sb_q) ? ('0 - acc_q) : acc_q;

  mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
    .divisor_i (mcand_q),
    .bit_i     (acc_q[WIDTH-1]),
    .rem_o     (div_rem),
    .q_o       (div_qbit)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = mdu_op_e'(op);
          sa_d    = op_signed && rs_data[WIDTH-1];
          sb_d    = op_signed && rt_data[WIDTH-1];
          dz_d    = op_is_div && (rt_data == '0);
          mcand_d = abs_rt;
          acc_d   = {{WIDTH{1'b0}}, abs_rs};
          cnt_d   = '0;
          state_d = ST_CALC;
`ifdef MDU_FAST_MULT_EN
          if (!op_is_div) begin
            acc_d   = fast_prod;
            state_d = ST_SIGN;
          end
`endif
        end else begin
          if (mthi) hi_d = rs_data;
          if (mtlo) lo_d = rs_data;
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(WIDTH)) begin
          state_d = ST_SIGN;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (is_div_q) acc_d = {div_rem, acc_q[WIDTH-2:0], div_qbit};
          else          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
      end
      ST_SIGN: begin
        state_d = ST_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            // Divide by zero leaves |dividend| as remainder; re-applying the
            // dividend sign restores rs_data as originally presented.
            lo_d = dz_q ? '1 : ((sa_q ^ sb_q) ? ('0 - quo) : quo);
            hi_d = sa_q ? ('0 - rem) : rem;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= MDU_MULT;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: vector table, hand-written corner sequences and randomized
// operations checked against an arithmetic reference model.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        reset, start, mthi, mtlo, flush;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        busy, done;
  logic [31:0] hi, lo;

  int unsigned checks = 0;
  int unsigned errors = 0;

  mdu_hilo #(.WIDTH(32), .CNT_W(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [1:0] o);
`ifdef MDU_FAST_MULT_EN
    if (!o[1]) return 2;
`endif
    return 35;
  endfunction

  // Reference: plain 64-bit arithmetic. Signed divide truncates toward zero
  // and the remainder follows the dividend, as in the architecture.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: p = 64'(sa * sb);
      2'b01: p = {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'd0)    p = {a, 32'hFFFF_FFFF};
        else if (o[0])     p = {a % b, a / b};
        else               p = {32'(sa % sb), 32'(sa / sb)};
      end
    endcase
    h = p[63:32];
    l = p[31:0];
  endfunction

  // Called just after a negedge; returns at the negedge of the done cycle
  // (or after the cycle budget). mt_cyc != 0 injects MTHI/MTLO while busy.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int mt_cyc);
    int          cyc, nb, dcyc;
    logic        got, busy_at_done;
    logic [31:0] hi_before;
    hi_before = hi;
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1; nb = 0; dcyc = 0; got = 1'b0; busy_at_done = 1'b1;
    while (cyc <= 80 && !got) begin
      if (mt_cyc != 0 && cyc == mt_cyc + 1) check({name, "_mt_ignored"}, {32'b0, hi}, {32'b0, hi_before});
      mthi = 1'b0; mtlo = 1'b0;
      if (busy) nb++;
      if (done) begin
        got = 1'b1; dcyc = cyc; busy_at_done = busy;
      end else begin
        if (mt_cyc != 0 && cyc == mt_cyc) begin
          mthi = 1'b1; mtlo = 1'b1; rs_data = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        cyc++;
      end
    end
    check({name, "_done_seen"}, {63'b0, got}, 64'd1);
    check({name, "_latency"}, 64'(dcyc), 64'(exp_lat(o)));
    check({name, "_busy_cycles"}, 64'(nb), 64'(exp_lat(o) - 1));
    check({name, "_busy_at_done"}, {63'b0, busy_at_done}, 64'd0);
    check({name, "_hilo"}, {hi, lo}, {eh, el});
  endtask

  initial begin
    logic [31:0] eh, el, a, b, phi, plo;
    logic [1:0]  o;
    logic        saw_busy, saw_done;

    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
    vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[6] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[7] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[8] = '{2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[9] = '{2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};

    // Reset with start held high: start must be ignored.
    reset = 1'b0; start = 1'b1; op = 2'b01; rs_data = 32'd5; rt_data = 32'd6;
    mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_done", {63'b0, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    start = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("reset_release_busy", {63'b0, busy}, 64'd0);

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
             vecs[i].exp_hi, vecs[i].exp_lo, 0);

    // MTHI then MTLO in IDLE, then both together.
    rs_data = 32'h1234_5678; mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_hi", {32'b0, hi}, {32'b0, 32'h1234_5678});
    check("mthi_lo_held", {32'b0, lo}, {32'b0, 32'h2345_6780});
    rs_data = 32'h9ABC_DEF0; mtlo = 1'b1;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo_hilo", {hi, lo}, {32'h1234_5678, 32'h9ABC_DEF0});
    rs_data = 32'h0BAD_F00D; mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check("mt_both", {hi, lo}, {32'h0BAD_F00D, 32'h0BAD_F00D});

    // MT* while busy is ignored; the result overwrites.
    run_op("mt_busy", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 5);

    // Flush in cycle 10 of DIVU 100/7.
    rs_data = 32'h1111_1111; mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    phi = hi; plo = lo;
    op = 2'b11; rs_data = 32'd100; rt_data = 32'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    saw_done = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    check("flush_busy_before", {63'b0, busy}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {63'b0, busy}, 64'd0);
    check("flush_no_done", {63'b0, done | saw_done}, 64'd0);
    check("flush_hilo", {hi, lo}, {phi, plo});
    run_op("after_flush", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 0);

    // Reset in cycle 20 of a MULTU, with start held during reset.
    op = 2'b01; rs_data = 32'hFFFF_FFFF; rt_data = 32'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    saw_done = 1'b0;
    for (int c = 1; c < 20; c++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    reset = 1'b0; start = 1'b1;
    @(negedge clk);
    check("midreset_busy", {63'b0, busy}, 64'd0);
    check("midreset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    saw_busy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done) saw_done = 1'b1;
      if (busy) saw_busy = 1'b1;
      @(negedge clk);
    end
    check("midreset_no_done", {63'b0, saw_done}, 64'd0);
    check("midreset_start_ignored", {63'b0, saw_busy}, 64'd0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      model(o, a, b, eh, el);
      run_op($sformatf("rnd%0d_op%0d_%h_%h", i, o, a, b), o, a, b, eh, el, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
